// File: rtl/add_round_key_seq_if.sv
// Block handshake bundle for add_round_key_seq: input block, result block and status.
interface add_round_key_seq_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 4
);
    logic                            i_valid;
    logic                            o_ready;
    logic [NUM_WORDS*DATA_WIDTH-1:0] i_state;
    logic [NUM_WORDS*DATA_WIDTH-1:0] i_key;
    logic                            i_bypass;
    logic                            o_valid;
    logic                            i_ready;
    logic [NUM_WORDS*DATA_WIDTH-1:0] dout;
    logic                            o_busy;

    modport master (
        output i_valid, i_state, i_key, i_bypass, i_ready,
        input  o_ready, o_valid, dout, o_busy
    );

    modport slave (
        input  i_valid, i_state, i_key, i_bypass, i_ready,
        output o_ready, o_valid, dout, o_busy
    );
endinterface

// File: rtl/add_round_key_seq.sv
// Sequential AddRoundKey: captures state/key, XORs LANES words per beat, holds result until consumed.
module add_round_key_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 4,
    parameter int unsigned LANES      = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    add_round_key_seq_if.slave bus
);
    localparam int unsigned BEATS = NUM_WORDS / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BW    = NUM_WORDS * DATA_WIDTH;

    if (LANES < 1 || (NUM_WORDS % LANES) != 0) begin : g_bad_lanes
        $error("add_round_key_seq: LANES must be >= 1 and divide NUM_WORDS");
    end

    typedef enum logic [1:0] {IDLE, XOR, HOLD} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   work;
    logic [BW-1:0]   key;
    logic            bypass;
    logic [BW-1:0]   work_next;
    logic [BW-1:0]   dout_q;
    logic            valid_q;
    logic            busy_q;
    logic            ready_q;

    // Only the words belonging to the current beat are updated; the rest pass through.
    always_comb begin
        work_next = work;
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
            if (!bypass && CW'(w / LANES) == cnt) begin
                work_next[(NUM_WORDS-w)*DATA_WIDTH-1 -: DATA_WIDTH] =
                    work[(NUM_WORDS-w)*DATA_WIDTH-1 -: DATA_WIDTH] ^
                    key[(NUM_WORDS-w)*DATA_WIDTH-1 -: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            key     <= '0;
            bypass  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        work    <= bus.i_state;
                        key     <= bus.i_key;
                        bypass  <= bus.i_bypass;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= XOR;
                    end
                end
                XOR: begin
                    work <= work_next;
                    if (cnt == CW'(BEATS - 1)) begin
                        dout_q  <= work_next;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = ready_q & ~i_rst;
    assign bus.o_valid = valid_q;
    assign bus.o_busy  = busy_q;
    assign bus.dout    = dout_q;
endmodule

// File: tb/tb_add_round_key_seq.sv
// Directed bench for add_round_key_seq across LANES=1, LANES=4 and an 8-word LANES=2 build.
module tb_add_round_key_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    localparam logic [127:0] FIPS_S = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    always #5 clk = ~clk;

    add_round_key_seq_if #(.DATA_WIDTH(32), .NUM_WORDS(4)) bus_a ();
    add_round_key_seq_if #(.DATA_WIDTH(32), .NUM_WORDS(4)) bus_b ();
    add_round_key_seq_if #(.DATA_WIDTH(32), .NUM_WORDS(8)) bus_c ();

    add_round_key_seq #(.DATA_WIDTH(32), .NUM_WORDS(4), .LANES(1)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    add_round_key_seq #(.DATA_WIDTH(32), .NUM_WORDS(4), .LANES(4)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));
    add_round_key_seq #(.DATA_WIDTH(32), .NUM_WORDS(8), .LANES(2)) dut_c (.i_clk(clk), .i_rst(rst), .bus(bus_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ticks until dut_a raises o_valid; 99 marks a timeout.
    task automatic wait_a(output int lat);
        lat = 0;
        while (bus_a.o_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (bus_a.o_valid !== 1'b1) lat = 99;
    endtask

    task automatic wait_c(output int lat);
        lat = 0;
        while (bus_c.o_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (bus_c.o_valid !== 1'b1) lat = 99;
    endtask

    initial begin
        int lat;
        logic [127:0] snap;
        bus_a.i_valid = 0; bus_a.i_state = '0; bus_a.i_key = '0; bus_a.i_bypass = 0; bus_a.i_ready = 1;
        bus_b.i_valid = 0; bus_b.i_state = '0; bus_b.i_key = '0; bus_b.i_bypass = 0; bus_b.i_ready = 1;
        bus_c.i_valid = 0; bus_c.i_state = '0; bus_c.i_key = '0; bus_c.i_bypass = 0; bus_c.i_ready = 1;

        // Reset state
        #2;
        chk("rst_ready", 256'(bus_a.o_ready), 256'(0));
        chk("rst_valid", 256'(bus_a.o_valid), 256'(0));
        chk("rst_busy",  256'(bus_a.o_busy),  256'(0));
        chk("rst_dout",  256'(bus_a.dout),    256'(0));
        tick();
        rst = 0;
        #1;
        chk("rel_ready", 256'(bus_a.o_ready), 256'(1));

        // FIPS-197 vector, LANES=1
        bus_a.i_state = FIPS_S; bus_a.i_key = FIPS_K; bus_a.i_valid = 1;
        tick();
        bus_a.i_valid = 0;
        chk("fips_busy",  256'(bus_a.o_busy),  256'(1));
        chk("fips_ready", 256'(bus_a.o_ready), 256'(0));
        wait_a(lat);
        chk("fips_lat",  256'(lat), 256'(4));
        chk("fips_dout", 256'(bus_a.dout), 256'(FIPS_R));
        tick();
        chk("fips_vld_fall", 256'(bus_a.o_valid), 256'(0));
        chk("fips_rdy_back", 256'(bus_a.o_ready), 256'(1));
        chk("fips_dout_keep", 256'(bus_a.dout), 256'(FIPS_R));

        // Bypass passes the state through
        bus_a.i_bypass = 1; bus_a.i_valid = 1;
        tick();
        bus_a.i_valid = 0; bus_a.i_bypass = 0;
        wait_a(lat);
        chk("byp_lat",  256'(lat), 256'(4));
        chk("byp_dout", 256'(bus_a.dout), 256'(FIPS_S));
        tick();

        // Backpressure with input churn during XOR and HOLD
        bus_a.i_state = FIPS_S; bus_a.i_key = FIPS_K; bus_a.i_ready = 0; bus_a.i_valid = 1;
        tick();
        bus_a.i_valid = 0;
        lat = 0;
        while (bus_a.o_valid !== 1'b1 && lat < 20) begin
            bus_a.i_state = {$urandom, $urandom, $urandom, $urandom};
            bus_a.i_key   = {$urandom, $urandom, $urandom, $urandom};
            bus_a.i_bypass = ~bus_a.i_bypass;
            tick();
            lat++;
        end
        chk("bp_lat", 256'(lat), 256'(4));
        for (int i = 0; i < 10; i++) begin
            bus_a.i_state = {$urandom, $urandom, $urandom, $urandom};
            bus_a.i_key   = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("bp_dout",  256'(bus_a.dout),    256'(FIPS_R));
            chk("bp_valid", 256'(bus_a.o_valid), 256'(1));
            chk("bp_ready", 256'(bus_a.o_ready), 256'(0));
            chk("bp_busy",  256'(bus_a.o_busy),  256'(1));
        end
        bus_a.i_ready = 1; bus_a.i_bypass = 0;
        tick();
        chk("bp_vld_fall", 256'(bus_a.o_valid), 256'(0));
        tick();
        chk("bp_single", 256'(bus_a.o_valid), 256'(0));

        // Reset between beat 2 and beat 3
        bus_a.i_state = 128'h00112233445566778899aabbccddeeff; bus_a.i_key = FIPS_K; bus_a.i_valid = 1;
        tick();
        bus_a.i_valid = 0;
        tick();
        tick();
        #2;
        rst = 1;
        #1;
        chk("mid_rst_valid", 256'(bus_a.o_valid), 256'(0));
        chk("mid_rst_dout",  256'(bus_a.dout),    256'(0));
        chk("mid_rst_busy",  256'(bus_a.o_busy),  256'(0));
        chk("mid_rst_ready", 256'(bus_a.o_ready), 256'(0));
        tick();
        rst = 0;
        #1;
        chk("post_rst_ready", 256'(bus_a.o_ready), 256'(1));
        chk("post_rst_valid", 256'(bus_a.o_valid), 256'(0));
        bus_a.i_state = FIPS_S; bus_a.i_key = FIPS_K; bus_a.i_valid = 1;
        tick();
        bus_a.i_valid = 0;
        wait_a(lat);
        chk("post_rst_lat",  256'(lat), 256'(4));
        chk("post_rst_dout", 256'(bus_a.dout), 256'(FIPS_R));
        tick();

        // LANES=4: two back-to-back blocks with i_valid held high
        bus_b.i_state = FIPS_S; bus_b.i_key = FIPS_K; bus_b.i_valid = 1;
        tick();
        chk("l4_busy", 256'(bus_b.o_busy), 256'(1));
        tick();
        chk("l4_valid", 256'(bus_b.o_valid), 256'(1));
        chk("l4_dout",  256'(bus_b.dout), 256'(FIPS_R));
        snap = FIPS_S ^ 128'h0f0f0f0f_00000000_ffffffff_12345678;
        bus_b.i_state = FIPS_S; bus_b.i_key = snap;
        tick();
        chk("l4_vld_fall", 256'(bus_b.o_valid), 256'(0));
        chk("l4_rdy_back", 256'(bus_b.o_ready), 256'(1));
        tick();
        chk("l4_second_acc", 256'(bus_b.o_ready), 256'(0));
        tick();
        bus_b.i_valid = 0;
        chk("l4_valid2", 256'(bus_b.o_valid), 256'(1));
        chk("l4_dout2",  256'(bus_b.dout), 256'(128'h0f0f0f0f_00000000_ffffffff_12345678));
        tick();
        tick();
        chk("l4_no_extra", 256'(bus_b.o_busy), 256'(0));

        // NUM_WORDS=8, LANES=2
        bus_c.i_state = {32{8'hFF}}; bus_c.i_key = {32{8'h5A}}; bus_c.i_valid = 1;
        tick();
        bus_c.i_valid = 0;
        wait_c(lat);
        chk("w8_lat",  256'(lat), 256'(4));
        chk("w8_dout", bus_c.dout, {32{8'hA5}});
        tick();
        bus_c.i_state = {4{64'h0123456789abcdef}}; bus_c.i_key = {4{64'h0123456789abcdef}}; bus_c.i_valid = 1;
        tick();
        bus_c.i_valid = 0;
        wait_c(lat);
        chk("w8_zero_lat",  256'(lat), 256'(4));
        chk("w8_zero_dout", bus_c.dout, 256'(0));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
